// File: rtl/clk_div_multi.sv
// Multi-channel programmable prescaler: independent periodic/one-shot enable pulses plus delayed copies.
// Optional macro CLKDIV_SYNC_START_EN adds a syncStart input that phase-aligns all running channels.
module clk_div_multi #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 10,
    parameter int DELAY  = 1
) (
    input  logic                      clk,
    input  logic                      resetN,
`ifdef CLKDIV_SYNC_START_EN
    input  logic                      syncStart,
`endif
    input  logic [NUM_CH-1:0]         chEnable,
    input  logic [NUM_CH-1:0]         oneShot,
    input  logic [NUM_CH*WIDTH-1:0]   preScaleValue,
    output logic [NUM_CH-1:0]         slowEnPulse,
    output logic [NUM_CH-1:0]         slowEnPulse_d,
    output logic [NUM_CH-1:0]         busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state   [NUM_CH];
    logic [WIDTH-1:0]  counter [NUM_CH];
    logic [WIDTH-1:0]  shadow  [NUM_CH];
    logic [NUM_CH-1:0] delay_line [DELAY];
    logic              sync_start;

`ifdef CLKDIV_SYNC_START_EN
    assign sync_start = syncStart;
`else
    assign sync_start = 1'b0;
`endif

    // The period value is captured into shadow only at start or wrap, so a
    // mid-period change of preScaleValue never shortens or stretches a period.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state[i]   <= IDLE;
                counter[i] <= '0;
                shadow[i]  <= '0;
            end
            slowEnPulse <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                case (state[i])
                    IDLE: begin
                        counter[i]     <= '0;
                        slowEnPulse[i] <= 1'b0;
                        if (chEnable[i]) begin
                            state[i]  <= RUN;
                            shadow[i] <= preScaleValue[i*WIDTH +: WIDTH];
                        end
                    end
                    RUN: begin
                        if (!chEnable[i]) begin
                            state[i]       <= IDLE;
                            counter[i]     <= '0;
                            slowEnPulse[i] <= 1'b0;
                        end else if (sync_start) begin
                            counter[i]     <= '0;
                            shadow[i]      <= preScaleValue[i*WIDTH +: WIDTH];
                            slowEnPulse[i] <= 1'b0;
                        end else if (counter[i] >= shadow[i]) begin
                            counter[i]     <= '0;
                            shadow[i]      <= preScaleValue[i*WIDTH +: WIDTH];
                            slowEnPulse[i] <= 1'b1;
                            if (oneShot[i])
                                state[i] <= DONE;
                        end else begin
                            counter[i]     <= counter[i] + 1'b1;
                            slowEnPulse[i] <= 1'b0;
                        end
                    end
                    DONE: begin
                        counter[i]     <= '0;
                        slowEnPulse[i] <= 1'b0;
                        if (!chEnable[i])
                            state[i] <= IDLE;
                    end
                    default: begin
                        state[i]       <= IDLE;
                        counter[i]     <= '0;
                        slowEnPulse[i] <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Delay line is deliberately not cleared on disable so in-flight pulses drain.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int k = 0; k < DELAY; k++)
                delay_line[k] <= '0;
        end else begin
            delay_line[0] <= slowEnPulse;
            for (int k = 1; k < DELAY; k++)
                delay_line[k] <= delay_line[k-1];
        end
    end

    assign slowEnPulse_d = delay_line[DELAY-1];

    always_comb begin
        busy = '0;
        for (int i = 0; i < NUM_CH; i++)
            busy[i] = (state[i] == RUN);
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed self-checking bench for clk_div_multi (NUM_CH=4, WIDTH=10, DELAY=1).
// Define CLKDIV_SYNC_START_EN for both files to also exercise syncStart.
module tb_clk_div_multi;

    logic        clk;
    logic        resetN;
    logic [3:0]  chEnable;
    logic [3:0]  oneShot;
    logic [39:0] preScaleValue;
    logic [3:0]  slowEnPulse;
    logic [3:0]  slowEnPulse_d;
    logic [3:0]  busy;
`ifdef CLKDIV_SYNC_START_EN
    logic        syncStart;
`endif

    int checks = 0;
    int errors = 0;

    clk_div_multi #(.NUM_CH(4), .WIDTH(10), .DELAY(1)) dut (
        .clk           (clk),
        .resetN        (resetN),
`ifdef CLKDIV_SYNC_START_EN
        .syncStart     (syncStart),
`endif
        .chEnable      (chEnable),
        .oneShot       (oneShot),
        .preScaleValue (preScaleValue),
        .slowEnPulse   (slowEnPulse),
        .slowEnPulse_d (slowEnPulse_d),
        .busy          (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        chEnable = '0;
        oneShot = '0;
        preScaleValue = '0;
`ifdef CLKDIV_SYNC_START_EN
        syncStart = 1'b0;
`endif
        #2;
        checks++;
        if ({slowEnPulse, slowEnPulse_d, busy} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h expected 000", {slowEnPulse, slowEnPulse_d, busy});
        end
        tick();
        tick();
        #3 resetN = 1'b1;
        tick();
        checks++;
        if ({slowEnPulse, slowEnPulse_d, busy} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: got %h expected 000", {slowEnPulse, slowEnPulse_d, busy});
        end
    endtask

    task automatic test_periodic();
        logic [3:0] exp_p, exp_d;
        preScaleValue[0*10 +: 10] = 10'd3;
        chEnable[0] = 1'b1;
        for (int k = 0; k < 14; k++) begin
            tick();
            exp_p = {3'b000, (k >= 4) && ((k - 4) % 4 == 0)};
            exp_d = {3'b000, (k >= 5) && ((k - 5) % 4 == 0)};
            checks++;
            if (slowEnPulse !== exp_p || slowEnPulse_d !== exp_d || busy !== 4'b0001) begin
                errors++;
                $display("[TB] FAIL periodic k=%0d: pulse=%b d=%b busy=%b expected %b %b 0001",
                         k, slowEnPulse, slowEnPulse_d, busy, exp_p, exp_d);
            end
        end
        chEnable[0] = 1'b0;
        tick();
        tick();
        checks++;
        if ({slowEnPulse, slowEnPulse_d, busy} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL periodic_stop: got %h expected 000", {slowEnPulse, slowEnPulse_d, busy});
        end
    endtask

    task automatic test_every_cycle();
        preScaleValue[1*10 +: 10] = 10'd0;
        chEnable[1] = 1'b1;
        tick();
        checks++;
        if (slowEnPulse !== 4'b0000 || busy !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL every_cycle_start: pulse=%b busy=%b expected 0000 0010", slowEnPulse, busy);
        end
        for (int k = 1; k < 8; k++) begin
            tick();
            checks++;
            if (slowEnPulse !== 4'b0010 || slowEnPulse_d !== ((k >= 2) ? 4'b0010 : 4'b0000)) begin
                errors++;
                $display("[TB] FAIL every_cycle k=%0d: pulse=%b d=%b", k, slowEnPulse, slowEnPulse_d);
            end
        end
        chEnable[1] = 1'b0;
        tick();
        checks++;
        if (slowEnPulse !== 4'b0000 || busy !== 4'b0000 || slowEnPulse_d !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL every_cycle_disable: pulse=%b busy=%b d=%b expected 0000 0000 0010",
                     slowEnPulse, busy, slowEnPulse_d);
        end
        tick();
        checks++;
        if (slowEnPulse_d !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL every_cycle_drain: d=%b expected 0000", slowEnPulse_d);
        end
    endtask

    task automatic test_oneshot();
        preScaleValue[2*10 +: 10] = 10'd5;
        oneShot[2] = 1'b1;
        chEnable[2] = 1'b1;
        for (int k = 0; k < 27; k++) begin
            tick();
            checks++;
            if (slowEnPulse !== ((k == 6) ? 4'b0100 : 4'b0000) ||
                busy !== ((k < 6) ? 4'b0100 : 4'b0000)) begin
                errors++;
                $display("[TB] FAIL oneshot k=%0d: pulse=%b busy=%b", k, slowEnPulse, busy);
            end
        end
        chEnable[2] = 1'b0;
        tick();
        chEnable[2] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (slowEnPulse !== ((k == 6) ? 4'b0100 : 4'b0000) ||
                busy !== ((k < 6) ? 4'b0100 : 4'b0000)) begin
                errors++;
                $display("[TB] FAIL oneshot_rearm k=%0d: pulse=%b busy=%b", k, slowEnPulse, busy);
            end
        end
        chEnable[2] = 1'b0;
        oneShot[2] = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_prescale_change();
        logic exp;
        preScaleValue[3*10 +: 10] = 10'd2;
        chEnable[3] = 1'b1;
        for (int k = 0; k < 1046; k++) begin
            tick();
            exp = (k == 3) || (k == 6) || (k == 13) || (k == 20) || (k == 1044);
            checks++;
            if (slowEnPulse !== {exp, 3'b000}) begin
                errors++;
                $display("[TB] FAIL prescale_change k=%0d: pulse=%b expected %b", k, slowEnPulse, {exp, 3'b000});
            end
            if (k == 4)  preScaleValue[3*10 +: 10] = 10'd6;
            if (k == 14) preScaleValue[3*10 +: 10] = 10'd1023;
        end
        chEnable[3] = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_async_reset();
        preScaleValue = {10'd2, 10'd4, 10'd0, 10'd3};
        oneShot = '0;
        chEnable = 4'hF;
        for (int k = 0; k < 5; k++)
            tick();
        checks++;
        if (slowEnPulse[1] !== 1'b1 || busy !== 4'hF) begin
            errors++;
            $display("[TB] FAIL pre_reset_running: pulse=%b busy=%b", slowEnPulse, busy);
        end
        #2 resetN = 1'b0;
        #1;
        checks++;
        if ({slowEnPulse, slowEnPulse_d, busy} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL async_reset: got %h expected 000", {slowEnPulse, slowEnPulse_d, busy});
        end
        tick();
        #2 resetN = 1'b1;
        tick();
        checks++;
        if (slowEnPulse !== 4'b0000 || busy !== 4'hF) begin
            errors++;
            $display("[TB] FAIL post_reset_first: pulse=%b busy=%b expected 0000 1111", slowEnPulse, busy);
        end
        tick();
        checks++;
        if (slowEnPulse !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL post_reset_second: pulse=%b expected 0010", slowEnPulse);
        end
        chEnable = '0;
        tick();
        tick();
    endtask

`ifdef CLKDIV_SYNC_START_EN
    task automatic test_sync_start();
        logic [3:0] exp_p;
        preScaleValue = {10'd0, 10'd0, 10'd7, 10'd3};
        chEnable[0] = 1'b1;
        tick();
        tick();
        chEnable[1] = 1'b1;
        for (int k = 0; k < 3; k++)
            tick();
        syncStart = 1'b1;
        tick();
        syncStart = 1'b0;
        for (int k = 0; k < 18; k++) begin
            exp_p = {2'b00, (k >= 8) && (k % 8 == 0), (k >= 4) && (k % 4 == 0)};
            checks++;
            if (slowEnPulse !== exp_p) begin
                errors++;
                $display("[TB] FAIL sync_start k=%0d: pulse=%b expected %b", k, slowEnPulse, exp_p);
            end
            tick();
        end
        chEnable = '0;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_periodic();
        test_every_cycle();
        test_oneshot();
        test_prescale_change();
        test_async_reset();
`ifdef CLKDIV_SYNC_START_EN
        test_sync_start();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
Multi-channel programmable prescaler that generates NUM_CH independent single-cycle enable pulses from one fast clock. Each channel has its own period, enable, and periodic/one-shot mode. Each channel also produces a configurable-depth delayed copy of its pulse, used to stagger DPRAM read/write accesses. It serves as the shared timing source for rate-limited logic such as prefetch pacing and slow-domain sampling.

Parameters:
NUM_CH, 4, number of independent channels (>=1)
WIDTH, 10, bit width of each channel's prescale value and counter (>=1)
DELAY, 1, pipeline depth in clk cycles of slowEnPulse_d relative to slowEnPulse (>=1)

Ports:
clk  input  1  system clock
resetN  input  1  asynchronous, active-low reset
chEnable  input  NUM_CH  per-channel run enable, level sensitive
oneShot  input  NUM_CH  per-channel mode: 1 = one pulse then stop, 0 = periodic
preScaleValue  input  NUM_CH*WIDTH  channel i period value at bits [i*WIDTH +: WIDTH]
slowEnPulse  output  NUM_CH  per-channel single-cycle enable pulse (registered)
slowEnPulse_d  output  NUM_CH  slowEnPulse delayed by DELAY cycles
busy  output  NUM_CH  1 while the channel is in RUN

Behaviour:
- Reset is asynchronous, active-low; clock is clk. On reset, per channel:
  - state=IDLE
  - counter=0, shadow=0
  - slowEnPulse=0, slowEnPulse_d=0 (whole delay line cleared), busy=0.
- Per-channel FSM, with states IDLE, RUN, DONE; all channels are fully independent.
- IDLE:
  - counter=0, pulse=0.
  - If chEnable[i]=1 at edge T: state<=RUN, counter<=0, shadow<=preScaleValue[i].
- RUN, evaluated each edge:
  - If chEnable[i]=0: state<=IDLE, counter<=0, pulse<=0.
  - Else if counter>=shadow (wrap):
    - counter<=0, pulse<=1, shadow<=preScaleValue[i] (reload).
    - If oneShot[i]=1, state<=DONE.
  - Else counter<=counter+1, pulse<=0.
- DONE:
  - pulse=0, counter held at 0.
  - Leaves only when chEnable[i]=0 (to IDLE); re-arming requires enable low for at least one cycle.
- Timing:
  - Period is shadow+1 cycles.
  - If enable is sampled at edge T, the first pulse is visible in the cycle after edge T+1+shadow.
  - shadow=0 gives a pulse every cycle, continuously.
- preScaleValue changes take effect only at the next wrap or start; the value never glitches the current period.
- oneShot is sampled at the wrap edge only.
- Counter never exceeds shadow, so no overflow at any WIDTH. The max value 2^WIDTH-1 gives a period of 2^WIDTH cycles.
- busy[i]=1 iff state==RUN (registered state decode).
- slowEnPulse_d:
  - DELAY-stage shift register of slowEnPulse.
  - Not cleared on disable: in-flight pulses drain normally; only reset clears it.
- Disable in the same cycle as a wrap: disable wins, no pulse is emitted.

Optional Feature:
CLKDIV_SYNC_START_EN:
- When defined, adds input syncStart (1 bit).
- A high cycle forces every channel with chEnable=1 and state IDLE or RUN to: state<=RUN, counter<=0, shadow<=preScaleValue[i], pulse<=0. This phase-aligns all channels.
- syncStart has priority over a wrap in the same cycle (that pulse is suppressed).
- DONE channels are unaffected.
- When not defined, the port is absent and behaviour is exactly as above.

Test Plan:
- Reset, then ch0 enable=1, preScale=3, periodic -> ch0 pulses every 4 cycles, first pulse 5 cycles after enable edge; slowEnPulse_d[0] follows 1 cycle later (DELAY=1); other channels stay 0.
- ch1 preScale=0, enable=1 -> slowEnPulse[1] high every cycle; deassert enable -> pulse low next cycle, busy[1]=0, delayed copy drains after DELAY cycles.
- ch2 oneShot=1, preScale=5 -> exactly one pulse, busy[2] drops with it, state DONE; enable held high for 20 cycles gives no further pulses; toggle enable low/high -> one new pulse 7 cycles after re-enable.
- ch3 preScale=2 running; change preScale to 6 mid-period -> current period stays 3 cycles, following periods 7 cycles; preScale=1023 (WIDTH=10) -> period 1024 with no overflow.
- Assert resetN low mid-count on all channels -> all outputs 0 immediately (asynchronous); after release, no pulse occurs until enable is resampled.
- With CLKDIV_SYNC_START_EN defined: ch0 preScale=3 and ch1 preScale=7, out of phase; pulse syncStart -> both counters restart, and from then on ch1 pulses coincide with every second ch0 pulse.
